cache_controller: RTL and testbench

- Initiator side of the 2-way data cache interface. Sits between the MEM stage and both the cache array and the SRAM controller.
- Serves pipeline loads from the cache on a hit. On a miss it fetches a 64-bit block from SRAM, fills the cache and returns the word.
- Stores are write-through, no-allocate: the store is forwarded to SRAM and any matching cache line is invalidated.
- Keeps saturating hit and miss counters for performance measurement.

---
 rtl/cache_controller.sv | 155 +++++++++++++++
 tb/tb_cache_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Initiator-side 2-way data cache controller between MEM stage, cache array and SRAM controller.
// Latency: load hit 0 cycles (same-cycle ready); load miss / store complete on the sram_ready cycle.
// Backpressure: ready is held low while a miss fill or write-through is outstanding at SRAM.
module cache_controller #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  // pipeline side
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [31:0]      address,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ready,
  // cache array side
  input  logic             cache_hit,
  input  logic [31:0]      cache_rdata,
  output logic             cache_read_en,
  output logic             cache_write_en,
  output logic             check_invalid,
  output logic [16:0]      cache_address,
  output logic [63:0]      cache_write_data,
  // SRAM controller side
  output logic             sram_rd_en,
  output logic             sram_wr_en,
  output logic [31:0]      sram_address,
  output logic [31:0]      sram_wdata,
  input  logic [63:0]      sram_rdata,
  input  logic             sram_ready,
  // statistics
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  // Cache indexing works on the offset into the data-memory window.
  logic [31:0] addr_off;
  logic        word_sel;
  logic        unused_addr_bits;

  assign addr_off         = address - BASE_ADDR;
  assign cache_address    = addr_off[18:2];
  assign word_sel         = addr_off[2];
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

  // The fill block and SRAM request fields are straight pass-throughs; the strobes qualify them.
  assign cache_write_data = sram_rdata;
  assign sram_address     = address;
  assign sram_wdata       = wdata;

  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

  // State register and saturating statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state, counter updates and all combinational outputs.
  always_comb begin
    state_d        = state_q;
    hit_d          = hit_q;
    miss_d         = miss_q;
    ready          = 1'b1;
    rdata          = '0;
    cache_read_en  = 1'b0;
    cache_write_en = 1'b0;
    check_invalid  = 1'b0;
    sram_rd_en     = 1'b0;
    sram_wr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A simultaneous load and store is treated as the store.
        if (wr_en) begin
          check_invalid = 1'b1;
          sram_wr_en    = 1'b1;
          ready         = 1'b0;
          state_d       = WRITE;
        end else if (rd_en) begin
          cache_read_en = 1'b1;
          if (cache_hit) begin
            rdata = cache_rdata;
            if (hit_q != '1) begin
              hit_d = hit_q + CNT_W'(1);
            end
          end else begin
            ready      = 1'b0;
            sram_rd_en = 1'b1;
            state_d    = READ_MISS;
            if (miss_q != '1) begin
              miss_d = miss_q + CNT_W'(1);
            end
          end
        end
      end

      READ_MISS: begin
        sram_rd_en = 1'b1;
        if (sram_ready) begin
          // Fill the line and forward the requested word in the same cycle.
          cache_write_en = 1'b1;
          rdata          = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
          state_d        = IDLE;
        end else begin
          ready = 1'b0;
        end
      end

      WRITE: begin
        sram_wr_en = 1'b1;
        if (sram_ready) begin
          state_d = IDLE;
        end else begin
          ready = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // While reset is held, everything is quiescent even if a request is still asserted.
    if (!rst) begin
      ready          = 1'b1;
      rdata          = '0;
      cache_read_en  = 1'b0;
      cache_write_en = 1'b0;
      check_invalid  = 1'b0;
      sram_rd_en     = 1'b0;
      sram_wr_en     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic          cache_hit = 1'b0;
  logic [31:0]   cache_rdata = '0;
  logic          cache_read_en;
  logic          cache_write_en;
  logic          check_invalid;
  logic [16:0]   cache_address;
  logic [63:0]   cache_write_data;
  logic          sram_rd_en;
  logic          sram_wr_en;
  logic [31:0]   sram_address;
  logic [31:0]   sram_wdata;
  logic [63:0]   sram_rdata = '0;
  logic          sram_ready = 1'b0;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  cache_controller #(.BASE_ADDR(1024), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
    .check_invalid(check_invalid), .cache_address(cache_address),
    .cache_write_data(cache_write_data),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Expected transaction outcome, pushed by the stimulus side.
  typedef struct {
    bit          store;
    bit          miss;
    int          lat;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [16:0] caddr;
    logic [63:0] blk;
  } exp_t;

  exp_t sb[$];
  int nvec = 0;
  int nmis = 0;

  // Reference memory: word-addressed contents, with a fixed pattern for never-written words.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] rd_block(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'd7;
    return {rd_word(base + 32'd4), rd_word(base)};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int stall = 0, ci = 0, cwe = 0, srd = 0, swr = 0;
  int mh = 0, mm = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        stall = 0; ci = 0; cwe = 0; srd = 0; swr = 0;
        mh = 0; mm = 0;
        check("rst_outputs", 64'({ready, cache_read_en, cache_write_en, check_invalid, sram_rd_en, sram_wr_en}), 64'b100000);
      end else if (rd_en || wr_en) begin
        if (!ready) stall++;
        if (check_invalid) ci++;
        if (cache_write_en) cwe++;
        if (sram_rd_en) srd++;
        if (sram_wr_en) swr++;
        if (ready) begin
          if (sb.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("stall_cycles", 64'(stall), 64'(e.lat));
            if (e.store) begin
              check("st_invalidate_cycles", 64'(ci), 64'd1);
              check("st_no_fill", 64'(cwe), 64'd0);
              check("st_no_sram_rd", 64'(srd), 64'd0);
              check("st_sram_wr_held", 64'(swr >= e.lat && swr <= e.lat + 1), 64'd1);
              check("st_sram_addr", 64'(sram_address), 64'(e.addr));
              check("st_sram_wdata", 64'(sram_wdata), 64'(e.wdata));
            end else begin
              check("ld_rdata", 64'(rdata), 64'(e.data));
              check("ld_cache_addr", 64'(cache_address), 64'(e.caddr));
              check("ld_fill_pulses", 64'(cwe), 64'(e.miss));
              check("ld_no_sram_wr", 64'(swr), 64'd0);
              check("ld_no_invalidate", 64'(ci), 64'd0);
              if (e.miss) begin
                check("ld_fill_block", cache_write_data, e.blk);
                check("ld_sram_rd_held", 64'(srd >= e.lat && srd <= e.lat + 1), 64'd1);
                check("ld_sram_addr", 64'(sram_address), 64'(e.addr));
                mm = sat_inc(mm);
              end else begin
                check("ld_hit_read_en", 64'(cache_read_en), 64'd1);
                check("ld_hit_no_sram", 64'(srd), 64'd0);
                mh = sat_inc(mh);
              end
            end
          end
          stall = 0; ci = 0; cwe = 0; srd = 0; swr = 0;
        end
      end else begin
        check("idle_outputs", 64'({ready, cache_read_en, cache_write_en, check_invalid, sram_rd_en, sram_wr_en}), 64'b100000);
        check("hit_count", 64'(hit_count), 64'(mh));
        check("miss_count", 64'(miss_count), 64'(mm));
      end
    end
  end

  // Reset must silence SRAM and fill strobes without waiting for a clock edge.
  initial begin
    forever begin
      @(negedge rst);
      #1;
      check("rst_async_outputs", 64'({sram_rd_en, sram_wr_en, cache_write_en, ready}), 64'b0001);
    end
  end

  // ---------------- stimulus ----------------
  // One pipeline transaction; lat is the SRAM response delay in cycles (unused for a load hit).
  task automatic txn(input bit st, input bit both, input bit hit, input logic [31:0] a,
                     input logic [31:0] wd, input int lat);
    exp_t e;
    int   g;
    e.store = st;
    e.miss  = !st && !hit;
    e.lat   = (st || !hit) ? lat : 0;
    e.addr  = a;
    e.wdata = wd;
    e.data  = rd_word(a);
    e.caddr = 17'((a - 32'd1024) >> 2);
    e.blk   = rd_block(a);
    if (st) mem[a & ~32'd3] = wd;
    sb.push_back(e);

    address     = a;
    wdata       = wd;
    rd_en       = !st || both;
    wr_en       = st;
    cache_hit   = hit;
    cache_rdata = hit ? e.data : $urandom;
    for (int c = 1; c <= e.lat; c++) begin
      @(posedge clk); #1;
      if (c == e.lat) begin
        sram_ready = 1'b1;
        sram_rdata = st ? {$urandom, $urandom} : e.blk;
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    sram_ready = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    cache_hit  = 1'b0;
    g = $urandom_range(1, 2);
    for (int i = 0; i < g; i++) begin
      // Stray completions while idle must be ignored.
      if ($urandom_range(0, 3) == 0) begin
        sram_ready = 1'b1;
        sram_rdata = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      sram_ready = 1'b0;
    end
  endtask

  initial begin
    int k;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    mem[32'd1024] = 32'h1111_1111;
    mem[32'd1028] = 32'h2222_2222;
    txn(0, 0, 0, 32'd1024, 32'd0, 3);            // miss, fill, low word
    txn(0, 0, 1, 32'd1028, 32'd0, 0);            // hit, zero latency
    txn(1, 0, 0, 32'd1024, 32'hDEAD_BEEF, 2);    // write-through store
    txn(0, 0, 0, 32'd1028, 32'd0, 1);            // miss returning high word
    txn(1, 1, 0, 32'd1040, $urandom, 1);         // load+store together acts as store
    for (int i = 0; i < 18; i++) txn(0, 0, 1, 32'd1024 + 32'(4 * i), 32'd0, 0);  // saturate hits

    // Reset in the middle of a miss, with a completion pulse landing during reset.
    address = 32'd1032; rd_en = 1'b1; cache_hit = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    sram_ready = 1'b1;
    sram_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    sram_ready = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    // The still-asserted load restarts as a fresh miss.
    txn(0, 0, 0, 32'd1032, 32'd0, 2);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      a = 32'd1024 + 32'($urandom_range(0, 63)) * 32'd4;
      if (k <= 4)      txn(0, 0, 1, a, 32'd0, 0);
      else if (k <= 7) txn(0, 0, 0, a, 32'd0, $urandom_range(1, 4));
      else if (k == 8) txn(1, 0, $urandom_range(0, 1), a, $urandom, $urandom_range(1, 4));
      else             txn(1, 1, $urandom_range(0, 1), a, $urandom, $urandom_range(1, 4));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2_000_000;
    nmis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
